// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered single-cycle ops plus iterative unsigned MULTU/DIVU into HI/LO.
// Define ALU_OVERFLOW_EN to add a registered signed-overflow flag for ADD/SUB.
module alu_muldiv #(
  parameter int unsigned B = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [B-1:0] op1,
  input  logic [B-1:0] op2,
  input  logic [3:0]   alu_control,
  output logic         out_valid,
  output logic [B-1:0] result,
  output logic         zero,
  output logic [B-1:0] hi,
  output logic [B-1:0] lo
`ifdef ALU_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int unsigned SW = $clog2(B);
  localparam int unsigned CW = SW + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(B - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [2*B-1:0] r_p;      // {acc/remainder, multiplier/quotient}
  logic [B-1:0]   r_opnd;   // multiplicand or divisor
  logic [B-1:0]   r_result, r_hi, r_lo;
  logic           r_zero, r_valid;

  logic [B-1:0]   w_alu, w_add, w_sub;
  logic [SW-1:0]  w_sh;
  logic           w_issue, w_single, w_div0, w_busy, w_done;
  logic [B:0]     w_mul_sum, w_div_sh, w_div_diff;
  logic [2*B-1:0] w_step;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;

  assign w_add    = op1 + op2;
  assign w_sub    = op1 - op2;
  assign w_sh     = op2[SW-1:0];
  assign w_issue  = in_valid && (r_state == ST_IDLE) && !flush;
  assign w_single = w_issue && (alu_control != OP_MULTU) && (alu_control != OP_DIVU);
  assign w_div0   = w_issue && (alu_control == OP_DIVU) && (op2 == '0);
  assign w_busy   = !flush && ((r_state == ST_MUL) || (r_state == ST_DIV));
  assign w_done   = w_busy && (r_cnt == LAST_STEP);

  always_comb begin
    w_alu = '1;
    unique case (alu_control)
      4'b0000: w_alu = op1 & op2;
      4'b0001: w_alu = op1 | op2;
      4'b0010: w_alu = w_add;
      4'b0110: w_alu = w_sub;
      4'b0111: w_alu = {{(B-1){1'b0}}, (op1 < op2)};
      4'b1000: w_alu = {{(B-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'b0011: w_alu = op1 ^ op2;
      4'b0100: w_alu = ~(op1 | op2);
      4'b0101: w_alu = op1 << w_sh;
      4'b1001: w_alu = op1 >> w_sh;
      4'b1010: w_alu = B'($signed(op1) >>> w_sh);
      4'b1101: w_alu = r_hi;
      4'b1110: w_alu = r_lo;
      default: w_alu = '1;
    endcase
  end

  // Shift-add multiply and restoring divide share the 2B-bit work register.
  assign w_mul_sum  = {1'b0, r_p[2*B-1:B]} + (r_p[0] ? {1'b0, r_opnd} : '0);
  assign w_div_sh   = r_p[2*B-1:B-1];
  assign w_div_diff = w_div_sh - {1'b0, r_opnd};

  always_comb begin
    if (r_state == ST_MUL) begin
      w_step = {w_mul_sum, r_p[B-1:1]};
    end else if (w_div_diff[B]) begin
      w_step = {w_div_sh[B-1:0], r_p[B-2:0], 1'b0};
    end else begin
      w_step = {w_div_diff[B-1:0], r_p[B-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_p      <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_hi     <= '0;
      r_lo     <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_p   <= w_step;
        r_cnt <= r_cnt + 1'b1;
        if (w_done) begin
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_hi     <= w_step[2*B-1:B];
          r_lo     <= w_step[B-1:0];
          r_result <= w_step[B-1:0];
          r_zero   <= (w_step[B-1:0] == '0);
          r_valid  <= 1'b1;
        end
      end else if (w_single) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
        r_valid  <= 1'b1;
      end else if (w_div0) begin
        r_hi     <= op1;
        r_lo     <= '1;
        r_result <= '1;
        r_zero   <= 1'b0;
        r_valid  <= 1'b1;
      end else if (w_issue) begin
        r_state <= (alu_control == OP_MULTU) ? ST_MUL : ST_DIV;
        r_cnt   <= '0;
        r_p     <= (alu_control == OP_MULTU) ? {{B{1'b0}}, op2} : {{B{1'b0}}, op1};
        r_opnd  <= (alu_control == OP_MULTU) ? op1 : op2;
      end
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (alu_control == 4'b0010) begin
      w_ovf = (op1[B-1] == op2[B-1]) && (w_add[B-1] != op1[B-1]);
    end else if (alu_control == 4'b0110) begin
      w_ovf = (op1[B-1] != op2[B-1]) && (w_sub[B-1] != op1[B-1]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_single) begin
      r_ovf <= w_ovf;
    end else if (w_done || w_div0) begin
      r_ovf <= 1'b0;
    end
  end

  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (B = 32); covers overflow when ALU_OVERFLOW_EN is set.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [3:0]  alu_control = '0;
  logic        out_valid;
  logic [31:0] result, hi, lo;
  logic        zero;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv #(.B(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op1         (op1),
    .op2         (op2),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .result      (result),
    .zero        (zero),
    .hi          (hi),
    .lo          (lo)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow    (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single rising edge, then sample 1 time unit after it.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    alu_control = op;
    op1         = a;
    op2         = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_vld"}, out_valid, 1'b1);
  endtask

  // cyc counts cycles after issue up to out_valid; busy counts cycles with in_ready low.
  task automatic wait_done(output int cyc, output int busy);
    cyc  = 1;
    busy = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (in_ready === 1'b0) busy++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc, busy, pulses;

    #12;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // back-to-back single-cycle ops
    drive(4'b0010, 32'd5, 32'd7);
    chk("add_res", result, 12);
    chk("add_zero", zero, 0);
    chk("add_vld", out_valid, 1);
    chk("add_rdy", in_ready, 1);
    drive(4'b0110, 32'd9, 32'd9);
    chk("sub_res", result, 0);
    chk("sub_zero", zero, 1);
    chk("sub_vld", out_valid, 1);
    @(posedge clk); #1;
    chk("idle_vld", out_valid, 0);
    chk("idle_hold", result, 0);

    single("slt",  4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single("sltu", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single("sra",  4'b1010, 32'h8000_0000, 32'd4, 32'hF800_0000);
    single("srl",  4'b1001, 32'h8000_0000, 32'd4, 32'h0800_0000);
    single("sll",  4'b0101, 32'd1, 32'd31, 32'h8000_0000);
    single("sllw", 4'b0101, 32'd1, 32'h21, 32'd2);
    single("and",  4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000);
    single("or",   4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    single("xor",  4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    single("nor",  4'b0100, 32'hF000_0000, 32'h0000_FFFF, 32'h0FFF_0000);
    single("subw", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF);
    single("addw", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("addw_zero", zero, 1);
    single("ones", 4'b1111, 32'd3, 32'd4, 32'hFFFF_FFFF);
    chk("single_hi", hi, 0);
    chk("single_lo", lo, 0);

    // MULTU with operands and a pending ADD changing while busy
    drive(4'b1011, 32'hFFFF_FFFF, 32'd2);
    chk("mul_rdy0", in_ready, 0);
    in_valid = 1'b1; alu_control = 4'b0010; op1 = 32'd1; op2 = 32'd1;
    wait_done(cyc, busy);
    in_valid = 1'b0;
    chk("mul_lat", cyc, 33);
    chk("mul_busy", busy, 32);
    chk("mul_hi", hi, 1);
    chk("mul_lo", lo, 32'hFFFF_FFFE);
    chk("mul_res", result, 32'hFFFF_FFFE);
    chk("mul_rdy1", in_ready, 1);
    @(posedge clk); #1;
    chk("mul_vld_pulse", out_valid, 0);

    drive(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, busy);
    chk("mul2_lat", cyc, 33);
    chk("mul2_hi", hi, 32'hFFFF_FFFE);
    chk("mul2_lo", lo, 32'h0000_0001);

    drive(4'b1100, 32'd100, 32'd7);
    op1 = 32'd0; op2 = 32'd0;
    wait_done(cyc, busy);
    chk("div_lat", cyc, 33);
    chk("div_lo", lo, 14);
    chk("div_hi", hi, 2);
    chk("div_res", result, 14);

    drive(4'b1100, 32'd5, 32'd0);
    chk("div0_vld", out_valid, 1);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 5);
    chk("div0_res", result, 32'hFFFF_FFFF);
    chk("div0_rdy", in_ready, 1);
    single("mfhi", 4'b1101, 32'd0, 32'd0, 32'd5);
    single("mflo", 4'b1110, 32'd0, 32'd0, 32'hFFFF_FFFF);

    // flush 10 cycles into a divide
    drive(4'b1100, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_rdy", in_ready, 1);
    chk("fl_vld", out_valid, 0);
    chk("fl_hi", hi, 5);
    chk("fl_lo", lo, 32'hFFFF_FFFF);
    chk("fl_res", result, 32'hFFFF_FFFF);
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) pulses++; end
    chk("fl_no_vld", pulses, 0);
    chk("fl_hi_late", hi, 5);

    // issue in the same cycle as flush is dropped
    flush = 1'b1;
    drive(4'b0010, 32'd1, 32'd1);
    flush = 1'b0;
    chk("fl_drop_vld", out_valid, 0);
    chk("fl_drop_res", result, 32'hFFFF_FFFF);
    single("post_fl", 4'b0010, 32'd20, 32'd22, 32'd42);

`ifdef ALU_OVERFLOW_EN
    drive(4'b0010, 32'h7FFF_FFFF, 32'd1);
    chk("ovf_add", overflow, 1);
    chk("ovf_res", result, 32'h8000_0000);
    drive(4'b0110, 32'h8000_0000, 32'd1);
    chk("ovf_sub", overflow, 1);
    drive(4'b0010, 32'd1, 32'd1);
    chk("ovf_clr", overflow, 0);
`endif

    // async reset in the middle of a multiply
    drive(4'b1011, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_result", result, 0);
    chk("arst_zero", zero, 1);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_vld", out_valid, 0);
    chk("arst_rdy", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(4'b1011, 32'd3, 32'd5);
    wait_done(cyc, busy);
    chk("arst_mul_lo", lo, 15);
    chk("arst_mul_lat", cyc, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
